// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product add and shift per step.
// The product output already includes the step being taken this cycle, so the
// caller can capture the final product on the same edge that performs step WIDTH.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     partial_sum;
  logic [2*WIDTH-1:0] acc_step;

  // Add the multiplicand into the high half when the current multiplier bit is set, then shift right.
  always_comb begin
    partial_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      partial_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
    acc_step = {partial_sum, acc[WIDTH-1:1]};
  end

  assign product = step ? acc_step : acc;
  assign last    = (count == LAST_COUNT);

  // Load operands with the multiplier in the low half, then advance one bit per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      count <= '0;
    end else if (step) begin
      acc   <= acc_step;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an iterative multiply,
// with a start/busy/done handshake. Define ALU_SIGNED_MULT_EN for two's-complement
// MULT (magnitudes multiplied, product negated when operand signs differ).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  alu_state_t state, state_next;

  logic               accept;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] mul_final;
  logic               mul_overflow;

  logic [WIDTH-1:0]   sum, diff, alu_result;
  logic               alu_overflow;

  assign accept   = (state == ST_IDLE) && start;
  assign mul_load = accept && (op == OP_MULT);
  assign mul_step = (state == ST_MUL);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  assign sum  = a + b;
  assign diff = a - b;

`ifdef ALU_SIGNED_MULT_EN
  logic neg_q;

  assign mul_a        = a[WIDTH-1] ? -a : a;
  assign mul_b        = b[WIDTH-1] ? -b : b;
  assign mul_final    = neg_q ? -mul_product : mul_product;
  assign mul_overflow = (mul_final[2*WIDTH-1:WIDTH] != {WIDTH{mul_final[WIDTH-1]}});

  // Remember whether the magnitude product must be negated when the multiply finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (mul_load) begin
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign mul_a        = a;
  assign mul_b        = b;
  assign mul_final    = mul_product;
  assign mul_overflow = |mul_product[2*WIDTH-1:WIDTH];
`endif

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .a       (mul_a),
    .b       (mul_b),
    .step    (mul_step),
    .product (mul_product),
    .last    (mul_last)
  );

  // Single-cycle datapath evaluated on the live inputs; its value is only captured on acceptance.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (op)
      OP_ADD: begin
        alu_result   = sum;
        alu_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result   = diff;
        alu_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  alu_result = a ^ b;
      OP_NOR:  alu_result = ~(a | b);
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      default: alu_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: single-cycle ops go straight to DONE, MULT iterates in MUL.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (op == OP_MULT) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output registers load only on the edge entering DONE and hold until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept && (op != OP_MULT)) begin
      result    <= alu_result;
      result_hi <= '0;
      zero      <= (alu_result == '0);
      overflow  <= alu_overflow;
    end else if (mul_step && mul_last) begin
      result    <= mul_final[WIDTH-1:0];
      result_hi <= mul_final[2*WIDTH-1:WIDTH];
      zero      <= (mul_final[WIDTH-1:0] == '0);
      overflow  <= mul_overflow;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result, result_hi;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h required=%0h", tag, observed, expected);
    end
  endtask

  // Reference: results derived from plain 64-bit signed/unsigned arithmetic.
  task automatic model(input logic [2:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                       output logic [W-1:0] r, output logic [W-1:0] rh, output logic ovf);
    longint          sa, sb, s;
    longint unsigned up;
    sa  = longint'($signed(m_a));
    sb  = longint'($signed(m_b));
    r   = '0;
    rh  = '0;
    ovf = 1'b0;
    case (m_op)
      OP_ADD: begin s = sa + sb; r = s[W-1:0]; ovf = (s > SMAX) || (s < SMIN); end
      OP_SUB: begin s = sa - sb; r = s[W-1:0]; ovf = (s > SMAX) || (s < SMIN); end
      OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      OP_XOR: r = m_a ^ m_b;
      OP_NOR: r = ~(m_a | m_b);
      OP_AND: r = m_a & m_b;
      OP_OR:  r = m_a | m_b;
      default: begin
`ifdef ALU_SIGNED_MULT_EN
        s   = sa * sb;
        r   = s[W-1:0];
        rh  = s[63:32];
        ovf = (s > SMAX) || (s < SMIN);
`else
        up  = {32'd0, m_a} * {32'd0, m_b};
        r   = up[W-1:0];
        rh  = up[63:32];
        ovf = (up > 64'h0000_0000_FFFF_FFFF);
`endif
      end
    endcase
  endtask

  // Drive one op from the current negedge; returns done latency (0 on timeout).
  task automatic applyStimulus(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                               input int inject, output int lat, output bit busy_ok);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 3'($urandom);
    a       = $urandom;
    b       = $urandom;
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (c == inject) begin
        start = 1'b1;
        op    = OP_ADD;
      end else if (c == inject + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [2:0] t_op, input logic [W-1:0] t_a,
                             input logic [W-1:0] t_b, input int inject);
    int           lat;
    bit           busy_ok;
    logic [W-1:0] r, rh;
    logic         ovf;
    applyStimulus(t_op, t_a, t_b, inject, lat, busy_ok);
    model(t_op, t_a, t_b, r, rh, ovf);
    checkOutput({tag, "_latency"}, 64'(lat), (t_op == OP_MULT) ? 64'd33 : 64'd1);
    if (lat != 0) begin
      checkOutput({tag, "_busy"}, 64'(busy_ok), 64'd1);
      checkOutput({tag, "_result"}, result, r);
      checkOutput({tag, "_result_hi"}, result_hi, rh);
      checkOutput({tag, "_zero"}, zero, (r == '0));
      checkOutput({tag, "_overflow"}, overflow, ovf);
      @(negedge clk);
      checkOutput({tag, "_pulse"}, {done, busy}, 2'b00);
      checkOutput({tag, "_hold"}, result, r);
    end
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit saw_done;
    reset = 1'b0;
    start = 1'b0;
    op    = OP_ADD;
    a     = '0;
    b     = '0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {busy, done, zero, overflow}, 4'b0000);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_result_hi", result_hi, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runAndCheck("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    checkOutput("add_ovf_const", {result, overflow}, {32'h8000_0000, 1'b1});
    runAndCheck("sub_zero", OP_SUB, 32'h5555_5555, 32'h5555_5555, 0);
    checkOutput("sub_zero_const", {zero, overflow}, 2'b10);
    runAndCheck("xor", OP_XOR, 32'hB37B_37B3, 32'h3373_37F3, 0);
    runAndCheck("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    checkOutput("slt_neg_const", result, 32'd1);
    runAndCheck("slt_pos", OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    runAndCheck("mul_ignore", OP_MULT, 32'h0001_0000, 32'h0001_0000, 5);
    checkOutput("mul_ignore_const", {result_hi, result, zero, overflow}, {32'd1, 32'd0, 2'b11});
    runAndCheck("mul_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 0);
`ifdef ALU_SIGNED_MULT_EN
    checkOutput("mul_neg_const", {result_hi, result}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    checkOutput("mul_neg_const", {result_hi, result}, 64'h0000_0004_FFFF_FFF1);
`endif

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'h0000_1234;
    b     = 32'h0000_5678;
    @(posedge clk);
    #1 start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_ctrl", {busy, done, zero, overflow}, 4'b0000);
    checkOutput("rst_mid_result", result, 32'd0);
    checkOutput("rst_mid_result_hi", result_hi, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("rst_mid_no_done", 64'(saw_done), 64'd0);
    runAndCheck("add_after_rst", OP_ADD, 32'd2, 32'd3, 0);
    checkOutput("add_after_rst_const", result, 32'd5);

    for (int i = 0; i < 40; i++) begin
      runAndCheck($sformatf("rand%0d", i), 3'($urandom), pickOperand(), pickOperand(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
